// File: rtl/cache_pkg.sv
// Shared cache-side types: bus words, the refill/data arbiter states and
// the grant-side encoding used by mem_arb.
package cache_pkg;

  localparam int unsigned WORD_W  = 32;
  localparam int unsigned WAIT_W  = 8;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [WAIT_W-1:0] wait_cnt_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    I_XFER = 2'd1,
    D_XFER = 2'd2,
    RESP   = 2'd3
  } arb_state_t;

  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } gnt_side_t;

endpackage : cache_pkg

// File: rtl/mem_arb.sv
// Round-robin arbiter sharing one single-outstanding memory port between the
// instruction refill path and the data path, with an ack timeout.
module mem_arb
  import cache_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_done,
  output logic [31:0] i_rdata,
  output logic        i_err,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_done,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam wait_cnt_t TIMEOUT_C = wait_cnt_t'(TIMEOUT);

  arb_state_t state_q, state_d;
  gnt_side_t  gnt_q, gnt_d;
  gnt_side_t  last_gnt_q, last_gnt_d;
  gnt_side_t  pick;
  wait_cnt_t  cnt_q, cnt_d, cnt_inc;
  word_t      addr_q, addr_d;
  word_t      wdata_q, wdata_d;
  word_t      i_rdata_q, i_rdata_d;
  word_t      d_rdata_q, d_rdata_d;
  logic       we_q, we_d;
  logic       err_q, err_d;

  // On a tie the side that did not win last time is chosen.
  assign pick    = (i_req && (!d_req || last_gnt_q == GNT_D)) ? GNT_I : GNT_D;
  assign cnt_inc = cnt_q + wait_cnt_t'(1);

  always_comb begin
    // NOTE: every next-state signal gets a hold default first so no path
    // through the case below can leave one unassigned and infer a latch.
    state_d    = state_q;
    gnt_d      = gnt_q;
    last_gnt_d = last_gnt_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    i_rdata_d  = i_rdata_q;
    d_rdata_d  = d_rdata_q;
    err_d      = 1'b0;

    unique case (state_q)
      IDLE: begin
        // The err-pulse cycle is treated like RESP: the aborted requester is
        // still holding req, so granting now would silently retry it.
        if (!err_q && (i_req || d_req)) begin
          gnt_d      = pick;
          last_gnt_d = pick;
          cnt_d      = '0;
          if (pick == GNT_I) begin
            state_d = I_XFER;
            addr_d  = i_addr;
            we_d    = 1'b0;
            wdata_d = '0;
          end else begin
            state_d = D_XFER;
            addr_d  = d_addr;
            we_d    = d_we;
            wdata_d = d_wdata;
          end
        end
      end
      I_XFER, D_XFER: begin
        if (mem_ack) begin
          state_d = RESP;
          cnt_d   = '0;
          if (gnt_q == GNT_I)  i_rdata_d = mem_rdata;
          else if (!we_q)      d_rdata_d = mem_rdata;
        end else if (cnt_inc == TIMEOUT_C) begin
          state_d = IDLE;
          cnt_d   = '0;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: the read-data holding registers are reset too, since they drive
  // outputs that must read zero out of reset; they are flops, not a RAM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      gnt_q      <= GNT_I;
      last_gnt_q <= GNT_I;
      cnt_q      <= '0;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      i_rdata_q  <= '0;
      d_rdata_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge values.
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      last_gnt_q <= last_gnt_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      i_rdata_q  <= i_rdata_d;
      d_rdata_q  <= d_rdata_d;
      err_q      <= err_d;
    end
  end

  // Decoded from the state register so reset removes mem_req asynchronously.
  assign mem_req   = (state_q == I_XFER) || (state_q == D_XFER);
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

  assign i_done  = (state_q == RESP) && (gnt_q == GNT_I);
  assign d_done  = (state_q == RESP) && (gnt_q == GNT_D);
  assign i_err   = err_q && (gnt_q == GNT_I);
  assign d_err   = err_q && (gnt_q == GNT_D);
  assign i_rdata = i_rdata_q;
  assign d_rdata = d_rdata_q;

endmodule : mem_arb

// File: tb/tb_mem_arb.sv
// Directed bench for mem_arb with TIMEOUT=4; expected values are hand-derived
// cycle by cycle from the arbiter's intended timing.
module tb_mem_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_req, d_req, d_we, mem_ack;
  logic [31:0] i_addr, d_addr, d_wdata, mem_rdata;
  logic        i_done, i_err, d_done, d_err, mem_req, mem_we;
  logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata;

  int n_checks = 0;
  int n_fail   = 0;

  mem_arb #(.TIMEOUT(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_req    (i_req),
    .i_addr   (i_addr),
    .i_done   (i_done),
    .i_rdata  (i_rdata),
    .i_err    (i_err),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_done   (d_done),
    .d_rdata  (d_rdata),
    .d_err    (d_err),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_ack  (mem_ack),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one clock; sampling and driving happen 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    i_req     = 1'b0;
    d_req     = 1'b0;
    d_we      = 1'b0;
    mem_ack   = 1'b0;
    i_addr    = '0;
    d_addr    = '0;
    d_wdata   = '0;
    mem_rdata = '0;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_i_rdata", i_rdata, 32'h0);
    check("rst_d_rdata", d_rdata, 32'h0);
    check("rst_pulses",  {28'd0, i_done, i_err, d_done, d_err}, 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);
    tick();
    rst_n = 1'b1;
    tick();

    // Instruction refill, ack on the third mem_req cycle.
    i_req = 1'b1; i_addr = 32'h100;
    tick();
    check("i1_mem_req_c1", 32'(mem_req), 32'd1);
    check("i1_mem_addr",   mem_addr, 32'h100);
    check("i1_mem_we",     32'(mem_we), 32'd0);
    tick();
    check("i1_mem_req_c2", 32'(mem_req), 32'd1);
    check("i1_addr_stable", mem_addr, 32'h100);
    tick();
    mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
    tick();
    mem_ack = 1'b0; mem_rdata = 32'h0;
    check("i1_mem_req_drop", 32'(mem_req), 32'd0);
    check("i1_done",  {30'd0, i_done, i_err}, 32'h2);
    check("i1_rdata", i_rdata, 32'hDEADBEEF);
    i_req = 1'b0;
    tick();
    check("i1_done_one_cycle", 32'(i_done), 32'd0);

    // Conflict right after reset goes to D; D re-requests at once, so the
    // next conflict goes to I, then D again.
    do_reset();
    i_req = 1'b1; i_addr = 32'h140;
    d_req = 1'b1; d_addr = 32'h300; d_we = 1'b0;
    tick();
    check("c1_first_addr", mem_addr, 32'h300);
    mem_ack = 1'b1; mem_rdata = 32'hA5A50001;
    tick();
    mem_ack = 1'b0;
    check("c1_d_done",  {30'd0, d_done, i_done}, 32'h2);
    check("c1_d_rdata", d_rdata, 32'hA5A50001);
    d_addr = 32'h304;
    tick();
    check("c1_idle_gap", 32'(mem_req), 32'd0);
    tick();
    check("c2_first_addr", mem_addr, 32'h140);
    check("c2_mem_we", 32'(mem_we), 32'd0);
    mem_ack = 1'b1; mem_rdata = 32'h11112222;
    tick();
    mem_ack = 1'b0;
    check("c2_i_done",  {30'd0, i_done, d_done}, 32'h2);
    check("c2_i_rdata", i_rdata, 32'h11112222);
    check("c2_d_rdata_hold", d_rdata, 32'hA5A50001);
    i_req = 1'b0;
    tick();
    tick();
    check("c3_addr", mem_addr, 32'h304);
    mem_ack = 1'b1; mem_rdata = 32'h5A5A0002;
    tick();
    mem_ack = 1'b0;
    check("c3_d_done",  32'(d_done), 32'd1);
    check("c3_d_rdata", d_rdata, 32'h5A5A0002);
    d_req = 1'b0;
    tick();

    // Data write: no read data is captured.
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h200; d_wdata = 32'h12345678;
    tick();
    check("w_mem_we",    32'(mem_we), 32'd1);
    check("w_mem_wdata", mem_wdata, 32'h12345678);
    check("w_mem_addr",  mem_addr, 32'h200);
    mem_ack = 1'b1; mem_rdata = 32'hFFFF0000;
    tick();
    mem_ack = 1'b0;
    check("w_d_done",    32'(d_done), 32'd1);
    check("w_d_rdata",   d_rdata, 32'h5A5A0002);
    d_req = 1'b0; d_we = 1'b0;
    tick();

    // Timeout: mem_req for exactly 4 cycles, then a single d_err.
    d_req = 1'b1; d_addr = 32'h400;
    for (int c = 1; c <= 4; c++) begin
      tick();
      check($sformatf("to_mem_req_c%0d", c), 32'(mem_req), 32'd1);
    end
    tick();
    check("to_mem_req_drop", 32'(mem_req), 32'd0);
    check("to_pulses", {28'd0, d_err, d_done, i_err, i_done}, 32'h8);
    d_req = 1'b0;
    tick();
    check("to_err_one_cycle", {30'd0, d_err, d_done}, 32'h0);
    check("to_idle", 32'(mem_req), 32'd0);

    // Ack on the cycle the counter reaches TIMEOUT: completion wins.
    i_req = 1'b1; i_addr = 32'h180;
    repeat (4) tick();
    check("ackto_mem_req_c4", 32'(mem_req), 32'd1);
    mem_ack = 1'b1; mem_rdata = 32'hCAFEF00D;
    tick();
    mem_ack = 1'b0;
    check("ackto_pulses", {30'd0, i_done, i_err}, 32'h2);
    check("ackto_rdata", i_rdata, 32'hCAFEF00D);
    i_req = 1'b0;
    tick();

    // Stray ack in IDLE is ignored.
    mem_ack = 1'b1; mem_rdata = 32'h99999999;
    tick();
    mem_ack = 1'b0;
    check("stray_pulses", {28'd0, i_done, i_err, d_done, d_err}, 32'h0);
    check("stray_rdata", i_rdata, 32'hCAFEF00D);

    // Requester drops d_req mid-transfer; completion still reported.
    d_req = 1'b1; d_addr = 32'h440;
    tick();
    d_req = 1'b0;
    tick();
    mem_ack = 1'b1; mem_rdata = 32'h0BADF00D;
    tick();
    mem_ack = 1'b0;
    check("drop_d_done", 32'(d_done), 32'd1);
    check("drop_d_rdata", d_rdata, 32'h0BADF00D);
    tick();

    // Reset during D_XFER drops mem_req asynchronously, no pulse afterwards.
    d_req = 1'b1; d_addr = 32'h480;
    tick();
    check("rx_mem_req", 32'(mem_req), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("rx_async_drop", 32'(mem_req), 32'd0);
    d_req = 1'b0;
    tick();
    check("rx_no_pulse", {28'd0, i_done, i_err, d_done, d_err}, 32'h0);
    rst_n = 1'b1;
    tick();
    check("rx_no_pulse_after", {28'd0, i_done, i_err, d_done, d_err}, 32'h0);
    check("rx_d_rdata_cleared", d_rdata, 32'h0);
    i_req = 1'b1; i_addr = 32'h500;
    tick();
    check("rx_i_addr", mem_addr, 32'h500);
    mem_ack = 1'b1; mem_rdata = 32'h76543210;
    tick();
    mem_ack = 1'b0;
    check("rx_i_done", 32'(i_done), 32'd1);
    check("rx_i_rdata", i_rdata, 32'h76543210);
    i_req = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_mem_arb

// File: doc/mem_arb.md
MEM_ARB -- requirements
Module: mem_arb

Interface
REQ-001 Parameter TIMEOUT, default 255, max cycles waiting for mem_ack before abort (1..255).
REQ-002 clk  input  1  single clock; all logic rising-edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 i_req  input  1  instruction-side refill request; held until i_done or i_err.
REQ-005 i_addr  input  32  instruction refill word address; stable while i_req high.
REQ-006 i_done  output  1  one-cycle pulse: instruction transfer complete, i_rdata valid.
REQ-007 i_rdata  output  32  instruction refill data; holds until next i_done.
REQ-008 i_err  output  1  one-cycle pulse: instruction transfer aborted by timeout.
REQ-009 d_req  input  1  data-side request; held until d_done or d_err.
REQ-010 d_we  input  1  data-side write (1) / read (0); stable while d_req high.
REQ-011 d_addr  input  32  data-side word address.
REQ-012 d_wdata  input  32  data-side write data.
REQ-013 d_done  output  1  one-cycle pulse: data transfer complete.
REQ-014 d_rdata  output  32  data-side read data; updated only on read completion.
REQ-015 d_err  output  1  one-cycle pulse: data transfer aborted by timeout.
REQ-016 mem_req  output  1  memory request, held high until mem_ack or abort.
REQ-017 mem_we  output  1  memory write enable, valid with mem_req.
REQ-018 mem_addr  output  32  memory address, valid with mem_req.
REQ-019 mem_wdata  output  32  memory write data, valid with mem_req.
REQ-020 mem_ack  input  1  memory completion; one cycle; mem_rdata valid same cycle.
REQ-021 mem_rdata  input  32  memory read data.

Function
REQ-022 FSM states IDLE, I_XFER, D_XFER, RESP shall be the only states.
REQ-023 IDLE: i_req only -> I_XFER; d_req only -> D_XFER; neither -> IDLE.
REQ-024 IDLE, both requesting: grant side not in last_gnt (round-robin); last_gnt updates on every grant.
REQ-025 On grant, address/we/wdata shall be registered; mem_req asserts the cycle after the request is seen in IDLE (1-cycle grant latency).
REQ-026 mem_req, mem_we, mem_addr, mem_wdata stay constant throughout XFER; mem_we = 0 for I_XFER.
REQ-027 XFER with mem_ack -> RESP; mem_req deasserts the same edge; mem_rdata captured into i_rdata or d_rdata (reads only).
REQ-028 RESP: pulse done of the granted side for exactly one cycle, then -> IDLE; no new grant in RESP.
REQ-029 Minimum request-to-done latency = 3 cycles (mem_ack on first mem_req cycle); back-to-back grants separated by one IDLE cycle.
REQ-030 8-bit wait counter clears on grant, increments each XFER cycle without mem_ack; reaching TIMEOUT -> drop mem_req, pulse err of granted side one cycle, -> IDLE; done not pulsed.
REQ-031 mem_ack on the cycle counter reaches TIMEOUT: ack wins, normal completion.
REQ-032 mem_ack outside XFER shall be ignored.
REQ-033 Requester dropping req mid-transfer: transfer still completes; done/err still pulses.
REQ-034 done and err for the same side shall never assert in the same cycle; i_* and d_* pulses never coincide.

Reset
REQ-035 rst_n low: state IDLE, last_gnt = I (first conflict goes to D), counter 0, all outputs 0, including i_rdata and d_rdata.
REQ-036 Reset mid-transfer aborts immediately: mem_req drops asynchronously, no done/err pulse follows.

Structure
REQ-037 State enum (arb_state_t) and grant-side enum (IDLE-free I/D) shall live in shared package cache_pkg with other cache typedefs.
REQ-038 Single module; no sub-modules; counter and FSM in one always_ff plus one combinational next-state block.

Verification
REQ-039 i_req, i_addr=0x100, mem_ack 2 cycles after mem_req, mem_rdata=0xDEADBEEF -> mem_addr=0x100, mem_we=0, i_done one cycle, i_rdata=0xDEADBEEF.
REQ-040 i_req and d_req same cycle after reset -> D granted first, I granted after d_done; repeat conflict -> I first.
REQ-041 d_req, d_we=1, d_addr=0x200, d_wdata=0x12345678 -> mem_we=1, mem_wdata=0x12345678, d_done pulses, d_rdata unchanged.
REQ-042 TIMEOUT=4, no mem_ack -> mem_req high 4 cycles, d_err one cycle, d_done never, FSM back to IDLE.
REQ-043 rst_n low during D_XFER -> mem_req 0 immediately, no d_done/d_err; after release fresh i_req serviced normally.
